// File: rtl/frame_sched_pkg.sv
// ============================================================================
// Module      : frame_sched_pkg
// Description : Shared types and defaults for the frame read scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_sched_pkg;

    localparam int NUM_PIXEL_DEFAULT = 307200;
    localparam int CNT_W_DEFAULT     = 19;
    localparam int DATA_W_DEFAULT    = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    typedef logic req_idx_t;

    function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin frame arbiter with pending request latch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
    import frame_sched_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_clr,
    input  req_idx_t   i_clr_idx,
    input  logic       i_served,
    input  req_idx_t   i_served_idx,
    output logic       o_any,
    output req_idx_t   o_pick
);

    logic [1:0] r_pending;
    req_idx_t   r_last_served;
    logic [1:0] w_eff;
    logic [1:0] w_clr_mask;

    // Same-cycle requests count, so an IDLE request is granted on the next edge.
    assign w_eff      = r_pending | i_req;
    assign w_clr_mask = i_clr ? idx_to_onehot(i_clr_idx) : 2'b00;

    always_comb begin
        o_any  = |w_eff;
        o_pick = 1'b0;
        case (w_eff)
            2'b01:   o_pick = 1'b0;
            2'b10:   o_pick = 1'b1;
            2'b11:   o_pick = ~r_last_served;
            default: o_pick = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending     <= 2'b00;
            r_last_served <= 1'b1;
        end else begin
            // A new request wins over the clear so the owner can queue its next frame.
            r_pending <= (r_pending & ~w_clr_mask) | i_req;
            if (i_served) begin
                r_last_served <= i_served_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_read_scheduler.sv
// ============================================================================
// Module      : frame_read_scheduler
// Description : Frame-granular round-robin sharing of the SDRAM read FIFO port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_read_scheduler
    import frame_sched_pkg::*;
#(
    parameter int NUM_PIXEL = NUM_PIXEL_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_req,
    output logic [1:0]        o_grant,
    output logic              o_frame_start,
    input  logic              i_fifo_empty,
    input  logic              i_ready,
    output logic              o_rd_req,
    input  logic [DATA_W-1:0] i_red,
    input  logic [DATA_W-1:0] i_green,
    input  logic [DATA_W-1:0] i_blue,
    output logic [DATA_W-1:0] o_red,
    output logic [DATA_W-1:0] o_green,
    output logic [DATA_W-1:0] o_blue,
    output logic              o_valid,
    output logic              o_owner,
    output logic [1:0]        o_done,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] c_num_pixel = CNT_W'(NUM_PIXEL);
    localparam logic [CNT_W-1:0] c_last_pix  = CNT_W'(NUM_PIXEL - 1);

    state_t           r_state;
    state_t           w_state_next;
    req_idx_t         r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic             r_strobe_d1;
    logic             r_last_d1;
    logic             w_any;
    req_idx_t         w_pick;
    logic             w_served;

    assign w_served = (r_state == S_DRAIN) && (|o_done);

    rr_arbiter2 u_arb (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_clr        (r_state == S_GRANT),
        .i_clr_idx    (r_owner),
        .i_served     (w_served),
        .i_served_idx (r_owner),
        .o_any        (w_any),
        .o_pick       (w_pick)
    );

    always_comb begin
        w_state_next = r_state;
        o_rd_req     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                w_state_next = S_STREAM;
            end
            S_STREAM: begin
                o_rd_req = !i_fifo_empty && i_ready && (r_cnt < c_num_pixel);
                if (o_rd_req && (r_cnt == c_last_pix)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // o_done marks the last beat leaving the output register.
                if (|o_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && w_any) begin
                r_owner <= w_pick;
            end
            if (r_state == S_GRANT) begin
                r_cnt <= '0;
            end else if (o_rd_req) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_strobe_d1 <= 1'b0;
            r_last_d1   <= 1'b0;
            o_valid     <= 1'b0;
            o_done      <= 2'b00;
            o_red       <= '0;
            o_green     <= '0;
            o_blue      <= '0;
            o_owner     <= 1'b0;
        end else begin
            r_strobe_d1 <= o_rd_req;
            r_last_d1   <= o_rd_req && (r_cnt == c_last_pix);
            o_valid     <= r_strobe_d1;
            o_done      <= r_last_d1 ? idx_to_onehot(r_owner) : 2'b00;
            if (r_strobe_d1) begin
                o_red   <= i_red;
                o_green <= i_green;
                o_blue  <= i_blue;
                o_owner <= r_owner;
            end
        end
    end

    assign o_grant       = (r_state != S_IDLE) ? idx_to_onehot(r_owner) : 2'b00;
    assign o_frame_start = (r_state == S_GRANT);
    assign o_busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_frame_read_scheduler.sv
// ============================================================================
// Module      : tb_frame_read_scheduler
// Description : Randomized and directed bench with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_read_scheduler;

    localparam int NP = 4;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic          empty = 1'b1;
    logic          ready = 1'b0;
    logic [DW-1:0] r_in = '0, g_in = '0, b_in = '0;
    logic [1:0]    grant, done;
    logic          frame_start, rd_req, valid, owner, busy;
    logic [DW-1:0] r_out, g_out, b_out;

    int checks = 0;
    int failures = 0;

    frame_read_scheduler #(.NUM_PIXEL(NP), .CNT_W(19), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_grant(grant),
        .o_frame_start(frame_start), .i_fifo_empty(empty), .i_ready(ready),
        .o_rd_req(rd_req), .i_red(r_in), .i_green(g_in), .i_blue(b_in),
        .o_red(r_out), .o_green(g_out), .o_blue(b_out), .o_valid(valid),
        .o_owner(owner), .o_done(done), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        r_in = DW'($urandom);
        g_in = DW'($urandom);
        b_in = DW'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit             armed = 1'b0;
    int             cyc = 0;
    bit [1:0]       m_pend;
    bit             m_last;
    bit             m_active;
    bit             m_owner;
    int             m_issued, m_grant_cyc, m_lst;
    bit             h_rd[4], h_lastb[4], h_own[4];
    logic [3*DW-1:0] h_dat[4];
    logic           e_rd, e_valid;
    logic [1:0]     e_grant, e_done, eff;
    logic           e_fs, e_busy;
    logic [1:0]     done_q[$];

    always @(negedge clk) begin
        if (armed) begin
            e_rd    = m_active && (cyc > m_grant_cyc) && (m_issued < NP) && !empty && ready;
            e_grant = m_active ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            e_fs    = m_active && (cyc == m_grant_cyc);
            e_busy  = m_active;
            e_valid = h_rd[(cyc + 2) % 4];
            e_done  = h_lastb[(cyc + 2) % 4] ? (h_own[(cyc + 2) % 4] ? 2'b10 : 2'b01) : 2'b00;
            chk("ctrl{rd,valid,grant,fs,busy,done}",
                32'({rd_req, valid, grant, frame_start, busy, done}),
                32'({e_rd, e_valid, e_grant, e_fs, e_busy, e_done}));
            if (e_valid) begin
                chk("pixel{owner,rgb}", 32'({owner, r_out, g_out, b_out}),
                    32'({h_own[(cyc + 2) % 4], h_dat[(cyc + 3) % 4]}));
            end
            if (done != 2'b00) done_q.push_back(done);

            // edge update
            if (!m_active) begin
                eff = m_pend | req;
                if (eff != 2'b00) begin
                    m_owner     = (eff == 2'b11) ? ~m_last : eff[1];
                    m_active    = 1'b1;
                    m_grant_cyc = cyc + 1;
                    m_issued    = 0;
                    m_lst       = -1;
                end
            end
            if (m_active && cyc == m_grant_cyc) m_pend[m_owner] = 1'b0;
            m_pend = m_pend | req;
            h_rd[cyc % 4]    = e_rd;
            h_own[cyc % 4]   = m_owner;
            h_dat[cyc % 4]   = {r_in, g_in, b_in};
            h_lastb[cyc % 4] = 1'b0;
            if (e_rd) begin
                m_issued++;
                if (m_issued == NP) begin
                    h_lastb[cyc % 4] = 1'b1;
                    m_lst = cyc;
                end
            end
            if (m_active && m_lst >= 0 && cyc == m_lst + 2) begin
                m_active = 1'b0;
                m_last   = m_owner;
            end
        end
        if (!rst_n) begin
            m_pend = 2'b00; m_last = 1'b1; m_active = 1'b0; m_owner = 1'b0;
            m_issued = 0; m_grant_cyc = -10; m_lst = -1;
            for (int i = 0; i < 4; i++) begin
                h_rd[i] = 1'b0; h_lastb[i] = 1'b0; h_own[i] = 1'b0;
            end
            armed = 1'b1;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        cyc_step();
        cyc_step();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        chk(name, 32'({grant, frame_start, rd_req, valid, done, busy, owner}), 32'd0);
        chk({name, "_rgb"}, 32'({r_out, g_out, b_out}), 32'd0);
    endtask

    initial begin
        int nv;
        do_reset();
        check_reset_outputs("reset_outputs");

        // Single frame, no stalls: literal timing from the request cycle.
        empty = 1'b0; ready = 1'b1;
        cyc_step();
        req = 2'b01;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("A_grant_k%0d", k), 32'(grant), (k >= 1 && k <= 7) ? 32'd1 : 32'd0);
            chk($sformatf("A_rd_k%0d", k), 32'(rd_req), (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("A_valid_k%0d", k), 32'(valid), (k >= 4 && k <= 7) ? 32'd1 : 32'd0);
            chk($sformatf("A_done_k%0d", k), 32'(done), (k == 7) ? 32'd1 : 32'd0);
            if (k == 1) chk("A_frame_start", 32'(frame_start), 32'd1);
            if (k == 8) chk("A_busy_after", 32'(busy), 32'd0);
            cyc_step();
            req = 2'b00;
        end

        // Simultaneous requests from reset: 0 first, then 1.
        do_reset();
        done_q.delete();
        req = 2'b11;
        cyc_step();
        req = 2'b00;
        repeat (25) cyc_step();
        chk("B_done_count", 32'(done_q.size()), 32'd2);
        if (done_q.size() == 2) begin
            chk("B_done_first", 32'(done_q[0]), 32'd1);
            chk("B_done_second", 32'(done_q[1]), 32'd2);
        end

        // Requests queued during a frame, including the current owner.
        do_reset();
        done_q.delete();
        req = 2'b01; cyc_step();
        req = 2'b00; cyc_step();
        req = 2'b10; cyc_step();
        req = 2'b01; cyc_step();
        req = 2'b00;
        repeat (40) cyc_step();
        chk("Q_done_count", 32'(done_q.size()), 32'd3);
        if (done_q.size() == 3) begin
            chk("Q_done_0", 32'(done_q[0]), 32'd1);
            chk("Q_done_1", 32'(done_q[1]), 32'd2);
            chk("Q_done_2", 32'(done_q[2]), 32'd1);
        end

        // Reset mid-frame after two beats.
        do_reset();
        req = 2'b01; cyc_step();
        req = 2'b00;
        nv = 0;
        for (int k = 0; k < 20 && nv < 2; k++) begin
            @(negedge clk);
            if (valid) nv++;
            cyc_step();
        end
        chk("R_two_beats_seen", 32'(nv), 32'd2);
        rst_n = 1'b0;
        done_q.delete();
        cyc_step();
        rst_n = 1'b1;
        check_reset_outputs("R_outputs_after_reset");
        repeat (10) cyc_step();
        chk("R_no_done", 32'(done_q.size()), 32'd0);
        req = 2'b01; cyc_step();
        req = 2'b00;
        @(negedge clk);
        chk("R_restart_frame_start", 32'(frame_start), 32'd1);
        nv = 0;
        for (int k = 0; k < 12; k++) begin
            cyc_step();
            @(negedge clk);
            if (valid) nv++;
        end
        chk("R_restart_beats", 32'(nv), 32'd4);
        chk("R_restart_done", 32'(done_q.size()), 32'd1);

        // Randomized traffic with stalls and occasional resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            req   = ($urandom % 12 == 0) ? 2'($urandom) : 2'b00;
            empty = ($urandom % 10) < 3;
            ready = ($urandom % 4) != 0;
            rst_n = ($urandom % 400) != 0;
            cyc_step();
        end
        rst_n = 1'b1; req = 2'b00; empty = 1'b0; ready = 1'b1;
        repeat (40) cyc_step();
        @(negedge clk);
        chk("final_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
